// File: rtl/clkmeas_pkg.sv
// Shared types for the strobe-period meter.
package clkmeas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

endpackage

// File: rtl/clkmeas_if.sv
// Strobe input / measurement output bundle of the period meter.
interface clkmeas_if #(
  parameter int DWC = 8
);
  logic           ena;
  logic           stb;
  logic [DWC-1:0] div;
  logic           vld;
  logic           lck;
  logic           ovf;

  modport master (
    output ena, stb,
    input  div, vld, lck, ovf
  );

  modport slave (
    input  ena, stb,
    output div, vld, lck, ovf
  );
endinterface

// File: rtl/clkmeas_lck.sv
// Lock tracker: counts consecutive identical measurements, saturating at LCK.
module clkmeas_lck #(
  parameter int DWC = 8,
  parameter int LCK = 4
) (
  input  logic           clk,
  input  logic           i_clr,
  input  logic           i_upd,
  input  logic [DWC-1:0] i_new,
  input  logic [DWC-1:0] i_prev,
  output logic           o_lck
);

  localparam int MW = $clog2(LCK + 1);

  logic [MW-1:0] r_mcnt;
  logic          r_lck;
  logic [MW-1:0] w_mnext;

  function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
    return (v == MW'(LCK)) ? v : v + 1'b1;
  endfunction

  // An empty history has no valid previous value, so it always restarts at one.
  assign w_mnext = (r_mcnt == '0 || i_new != i_prev) ? MW'(1) : sat_inc(r_mcnt);

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_mcnt <= '0;
      r_lck  <= 1'b0;
    end else if (i_upd) begin
      r_mcnt <= w_mnext;
      r_lck  <= (w_mnext == MW'(LCK));
    end
  end

  assign o_lck = r_lck;

endmodule

// File: rtl/clkmeas.sv
// Strobe-period meter: recovers the divider ratio (period - 1) of a strobe train,
// flags lock on LCK identical measurements and overflow past 2^DWC cycles.
module clkmeas
  import clkmeas_pkg::*;
#(
  parameter int DWC = 8,
  parameter int LCK = 4
) (
  input  logic     clk,
  input  logic     rstn,
  clkmeas_if.slave bus
);

  state_t         r_state;
  logic [DWC-1:0] r_cnt;
  logic [DWC-1:0] r_div;
  logic           r_vld;
  logic           r_ovf;

  logic           w_clr;
  logic           w_meas;
  logic           w_ovf;
  logic           w_lck;

  assign w_clr  = !rstn || !bus.ena;
  assign w_meas = (r_state == MEAS) && bus.stb;
  assign w_ovf  = (r_state == MEAS) && !bus.stb && (r_cnt == '1);

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_vld   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      r_ovf <= 1'b0;
      case (r_state)
        IDLE: r_state <= ARM;
        // The first strobe only opens a period; there is nothing to report yet.
        ARM: begin
          if (bus.stb) begin
            r_state <= MEAS;
            r_cnt   <= '0;
          end
        end
        MEAS: begin
          if (bus.stb) begin
            r_cnt <= '0;
            r_div <= r_cnt;
            r_vld <= 1'b1;
          end else if (r_cnt == '1) begin
            // Period too long to represent: report and re-arm instead of wrapping.
            r_ovf   <= 1'b1;
            r_cnt   <= '0;
            r_state <= ARM;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  clkmeas_lck #(
    .DWC (DWC),
    .LCK (LCK)
  ) u_lck (
    .clk    (clk),
    .i_clr  (w_clr || w_ovf),
    .i_upd  (w_meas),
    .i_new  (r_cnt),
    .i_prev (r_div),
    .o_lck  (w_lck)
  );

  assign bus.div = r_div;
  assign bus.vld = r_vld;
  assign bus.lck = w_lck;
  assign bus.ovf = r_ovf;

endmodule

// File: tb/tb_clkmeas.sv
// Bench for clkmeas: divider-style and random strobe trains against a timestamp model.
module tb_clkmeas;

  localparam int DWC  = 8;
  localparam int LCK  = 4;
  localparam int PMAX = 1 << DWC;

  logic clk;
  logic rstn;

  clkmeas_if #(.DWC(DWC)) bus ();

  clkmeas #(
    .DWC (DWC),
    .LCK (LCK)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  int ovf_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: timestamp of the reference strobe and the list of recent ratios.
  int        cyc = 0;
  bit        since_en = 1'b0;
  bit        have_ref = 1'b0;
  int        t_ref = 0;
  int        hist[$];
  int        e_div = 0;
  bit        e_vld = 1'b0;
  bit        e_lck = 1'b0;
  bit        e_ovf = 1'b0;

  function automatic bit lock_ok();
    if (hist.size() < LCK) return 1'b0;
    foreach (hist[i]) if (hist[i] != hist[0]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rstn || !bus.ena) begin
      since_en = 1'b0;
      have_ref = 1'b0;
      hist.delete();
      e_div = 0; e_vld = 1'b0; e_lck = 1'b0; e_ovf = 1'b0;
    end else begin
      e_vld = 1'b0;
      e_ovf = 1'b0;
      if (!since_en) begin
        since_en = 1'b1;
      end else if (have_ref) begin
        if (bus.stb) begin
          e_div = cyc - t_ref - 1;
          e_vld = 1'b1;
          hist.push_back(e_div);
          if (hist.size() > LCK) void'(hist.pop_front());
          e_lck = lock_ok();
          t_ref = cyc;
        end else if (cyc - t_ref == PMAX) begin
          e_ovf = 1'b1;
          have_ref = 1'b0;
          hist.delete();
          e_lck = 1'b0;
        end
      end else if (bus.stb) begin
        have_ref = 1'b1;
        t_ref = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("div", bus.div, e_div);
      check("vld", bus.vld, e_vld);
      check("lck", bus.lck, e_lck);
      check("ovf", bus.ovf, e_ovf);
      if (bus.vld && bus.ovf) check("vld_ovf_excl", 1, 0);
      if (bus.ovf) ovf_cnt++;
    end
  end

  // Behavioural clock-enable divider: one strobe every ratio+1 cycles.
  int ratio = 0;
  int ph = 0;

  task automatic dcycle();
    @(posedge clk);
    #1;
    bus.stb = (ph == 0);
    ph = (ph >= ratio) ? 0 : ph + 1;
  endtask

  task automatic scycle(input bit s);
    @(posedge clk);
    #1;
    bus.stb = s;
  endtask

  int ovf0;
  bit found;

  initial begin
    rstn = 1'b0;
    bus.ena = 1'b0;
    bus.stb = 1'b0;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    repeat (2) scycle(1'b1);
    @(negedge clk);
    check("rst_div", bus.div, 0);
    check("rst_vld", bus.vld, 0);
    check("rst_lck", bus.lck, 0);
    check("rst_ovf", bus.ovf, 0);

    // Divider ratio 9
    rstn = 1'b1;
    bus.ena = 1'b1;
    ratio = 9; ph = 0;
    repeat (80) dcycle();
    @(negedge clk);
    check("s1_div", bus.div, 9);
    check("s1_lck", bus.lck, 1);
    check("s1_ovf_cnt", ovf_cnt, 0);

    // Switch to ratio 11 while locked
    ratio = 11;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      dcycle();
      @(negedge clk);
      if (bus.vld && bus.div == 11) begin
        found = 1'b1;
        check("s4_first_lck", bus.lck, 0);
      end
    end
    check("s4_found", found, 1);
    repeat (60) dcycle();
    @(negedge clk);
    check("s4_div", bus.div, 11);
    check("s4_lck", bus.lck, 1);

    // Ratio 0: strobe held high
    ratio = 0; ph = 0;
    repeat (10) dcycle();
    @(negedge clk);
    check("s2_div", bus.div, 0);
    check("s2_lck", bus.lck, 1);
    check("s2_vld", bus.vld, 1);

    // Overflow, then a period of exactly 2^DWC
    ovf0 = ovf_cnt;
    scycle(1'b1);
    repeat (300) scycle(1'b0);
    @(negedge clk);
    check("s3_ovf_cnt", ovf_cnt - ovf0, 1);
    check("s3_lck", bus.lck, 0);
    check("s3_div", bus.div, 0);
    scycle(1'b1);
    repeat (255) scycle(1'b0);
    scycle(1'b1);
    scycle(1'b0);
    @(negedge clk);
    check("s3_div255", bus.div, 255);
    check("s3_vld255", bus.vld, 1);
    check("s3_ovf_cnt2", ovf_cnt - ovf0, 1);

    // One-cycle ena drop while locked
    ratio = 9; ph = 0;
    repeat (60) dcycle();
    @(negedge clk);
    check("s5_lck_pre", bus.lck, 1);
    dcycle();
    bus.ena = 1'b0;
    dcycle();
    bus.ena = 1'b1;
    @(negedge clk);
    check("s5_div", bus.div, 0);
    check("s5_lck", bus.lck, 0);
    check("s5_vld", bus.vld, 0);
    repeat (40) dcycle();
    @(negedge clk);
    check("s5_div_after", bus.div, 9);

    // Reset during MEAS with the strobe active
    for (int i = 0; i < 20; i++) begin
      dcycle();
      if (bus.stb) break;
    end
    rstn = 1'b0;
    dcycle();
    rstn = 1'b1;
    @(negedge clk);
    check("s6_div", bus.div, 0);
    check("s6_vld", bus.vld, 0);
    check("s6_lck", bus.lck, 0);
    check("s6_ovf", bus.ovf, 0);
    repeat (80) dcycle();
    @(negedge clk);
    check("s6_div_after", bus.div, 9);
    check("s6_lck_after", bus.lck, 1);

    // Randomized segments
    for (int seg = 0; seg < 60; seg++) begin
      int m;
      m = $urandom_range(0, 9);
      if (m < 6) begin
        ratio = $urandom_range(0, 12);
        ph = 0;
        repeat ($urandom_range(15, 60)) dcycle();
      end else if (m == 6) begin
        scycle(1'b1);
        repeat (253 + $urandom_range(0, 5)) scycle(1'b0);
        scycle(1'b1);
      end else if (m == 7) begin
        repeat (40) scycle($urandom_range(0, 2) == 0);
      end else if (m == 8) begin
        scycle($urandom_range(0, 1));
        bus.ena = 1'b0;
        repeat ($urandom_range(1, 3)) scycle($urandom_range(0, 1));
        bus.ena = 1'b1;
      end else begin
        scycle($urandom_range(0, 1));
        rstn = 1'b0;
        repeat ($urandom_range(1, 3)) scycle($urandom_range(0, 1));
        rstn = 1'b1;
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
